// File: rtl/wb_rdwr_sched.sv
// Two-port Wishbone pipelined scheduler: round-robin grant with a burst fairness limit.
// Define WBSCHED_TIMEOUT_EN to add a stuck-slave timeout that is reported as a bus error.
module wb_rdwr_sched #(
  parameter int unsigned AW         = 26,
  parameter int unsigned DW         = 32,
  parameter int unsigned LGMAXBURST = 4,
  parameter int unsigned LGOUT      = 5,
  parameter int unsigned LGTIMEOUT  = 10
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  output logic [1:0]      o_owner
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, DRAIN} state_t;

  localparam logic [LGMAXBURST:0] BURST_MAX = {1'b1, {LGMAXBURST{1'b0}}};

  state_t            state_q, state_d;
  logic              lastb_q, lastb_d;
  logic [LGOUT-1:0]  out_q, out_d;
  logic [LGMAXBURST:0] burst_q, burst_d;
  logic              err_q, err_d;

  logic own_b, own_cyc, own_stb, oth_cyc, in_gnt, full, preempt;
  logic cyc_raw, accept, ack_in, buserr, own_stall, to_fire;

  // The last-owner flag is updated on every grant, so it also names the current owner.
  always_comb begin
    in_gnt  = (state_q == GNT_A) || (state_q == GNT_B);
    own_b   = lastb_q;
    own_cyc = own_b ? i_b_cyc : i_a_cyc;
    own_stb = own_b ? i_b_stb : i_a_stb;
    oth_cyc = own_b ? i_a_cyc : i_b_cyc;
    full    = &out_q;
    preempt = in_gnt && oth_cyc && (burst_q == BURST_MAX);

    cyc_raw = 1'b0;
    if (!err_q) begin
      if (in_gnt)               cyc_raw = own_cyc;
      else if (state_q == DRAIN) cyc_raw = own_cyc && (out_q != '0);
    end

    o_wb_cyc  = cyc_raw;
    o_wb_stb  = cyc_raw && in_gnt && own_stb && !preempt && !full;
    o_wb_we   = own_b ? i_b_we   : i_a_we;
    o_wb_addr = own_b ? i_b_addr : i_a_addr;
    o_wb_data = own_b ? i_b_data : i_a_data;
    o_wb_sel  = own_b ? i_b_sel  : i_a_sel;

    accept = o_wb_stb && !i_wb_stall;
    ack_in = cyc_raw && i_wb_ack;
    buserr = cyc_raw && (i_wb_err || to_fire);

    own_stall = !in_gnt || err_q || i_wb_stall || preempt || full;

    o_a_ack   = ack_in && !own_b;
    o_b_ack   = ack_in && own_b;
    o_a_err   = buserr && !own_b;
    o_b_err   = buserr && own_b;
    o_a_stall = own_b ? 1'b1 : own_stall;
    o_b_stall = own_b ? own_stall : 1'b1;

    case (state_q)
      GNT_A:   o_owner = 2'b01;
      GNT_B:   o_owner = 2'b10;
      DRAIN:   o_owner = lastb_q ? 2'b10 : 2'b01;
      default: o_owner = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lastb_d = lastb_q;
    err_d   = buserr;

    out_d = out_q;
    if (accept && !ack_in)
      out_d = out_q + 1'b1;
    else if (!accept && ack_in && (out_q != '0))
      out_d = out_q - 1'b1;
    // Errors and a dropped owner cycle abandon everything in flight.
    if (buserr || !own_cyc || (state_q == IDLE))
      out_d = '0;

    burst_d = burst_q;
    if (accept && (burst_q != BURST_MAX))
      burst_d = burst_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (i_a_cyc && (!i_b_cyc || lastb_q)) begin
          state_d = GNT_A;
          lastb_d = 1'b0;
          burst_d = '0;
        end else if (i_b_cyc) begin
          state_d = GNT_B;
          lastb_d = 1'b1;
          burst_d = '0;
        end
      end
      GNT_A, GNT_B: begin
        if (!own_cyc)
          state_d = IDLE;
        else if (preempt)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (out_d == '0) begin
          if (oth_cyc) begin
            state_d = own_b ? GNT_A : GNT_B;
            lastb_d = !lastb_q;
            burst_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      lastb_q <= 1'b1;
      out_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lastb_q <= lastb_d;
      out_q   <= out_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

`ifdef WBSCHED_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] to_q, to_d;

  assign to_fire = &to_q;

  always_comb begin
    to_d = to_q + 1'b1;
    if (ack_in || (out_d == '0) || (state_d != state_q))
      to_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) to_q <= '0;
    else         to_q <= to_d;
  end
`else
  logic [31:0] unused_lgtimeout;
  assign unused_lgtimeout = LGTIMEOUT;
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rdwr_sched.sv
// Directed self-checking bench for wb_rdwr_sched (honours WBSCHED_TIMEOUT_EN if defined).
module tb_wb_rdwr_sched;
  localparam int AW = 26;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_cyc = 0, a_stb = 0, a_we = 0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic [DW/8-1:0] a_sel = '1;
  logic a_ack, a_stall, a_err;
  logic b_cyc = 0, b_stb = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic [DW/8-1:0] b_sel = '1;
  logic b_ack, b_stall, b_err;
  logic wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW/8-1:0] wb_sel;
  logic wb_ack = 0, wb_stall = 0, wb_err = 0;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  wb_rdwr_sched #(.AW(AW), .DW(DW), .LGMAXBURST(4), .LGOUT(5), .LGTIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_sel(a_sel),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_sel(b_sel),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .o_owner(owner)
  );

  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", owner); end
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b%b exp 00", wb_cyc, wb_stb); end
    checks++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b%b exp 11", a_stall, b_stall); end
    checks++; if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin errors++; $display("FAIL reset_resp got %b exp 0000", {a_ack, a_err, b_ack, b_err}); end
    nxt; rst = 1'b0; #1;
    checks++; if (owner !== 2'b00 || wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_release got %b/%b exp 00/0", owner, wb_cyc); end
  endtask

  task automatic test_both_same_cycle;
    nxt; a_cyc = 1; b_cyc = 1; #1;
    checks++; if (owner !== 2'b00 || a_stall !== 1'b1) begin errors++; $display("FAIL both_latency got %b/%b exp 00/1", owner, a_stall); end
    nxt; #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL both_first got %b exp 01", owner); end
    checks++; if (b_stall !== 1'b1 || a_stall !== 1'b0) begin errors++; $display("FAIL both_stalls got a%b b%b exp a0 b1", a_stall, b_stall); end
    a_cyc = 0; #1;
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL both_drop_cyc got %b exp 0", wb_cyc); end
    nxt; #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL both_idle got %b exp 00", owner); end
    nxt; #1;
    checks++; if (owner !== 2'b10 || b_stall !== 1'b0 || a_stall !== 1'b1) begin errors++; $display("FAIL both_second got %b a%b b%b exp 10 a1 b0", owner, a_stall, b_stall); end
    b_cyc = 0;
    nxt; #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL both_release got %b exp 00", owner); end
    a_cyc = 1; b_cyc = 1;
    nxt; #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL both_lastowner got %b exp 01", owner); end
    a_cyc = 0; b_cyc = 0;
    nxt; nxt;
  endtask

  task automatic test_single_a;
    nxt; a_cyc = 1; a_stb = 1; a_we = 0; a_addr = 26'h0000123; #1;
    checks++; if (owner !== 2'b00 || a_stall !== 1'b1 || wb_cyc !== 1'b0) begin errors++; $display("FAIL single_latency got %b/%b/%b exp 00/1/0", owner, a_stall, wb_cyc); end
    nxt; #1;
    checks++; if (owner !== 2'b01 || wb_stb !== 1'b1 || a_stall !== 1'b0) begin errors++; $display("FAIL single_grant got %b/%b/%b exp 01/1/0", owner, wb_stb, a_stall); end
    checks++; if (wb_addr !== 26'h0000123 || wb_we !== 1'b0) begin errors++; $display("FAIL single_addr got %h/%b exp 123/0", wb_addr, wb_we); end
    nxt; a_stb = 0; #1;
    checks++; if (wb_stb !== 1'b0 || a_ack !== 1'b0) begin errors++; $display("FAIL single_wait got %b/%b exp 0/0", wb_stb, a_ack); end
    nxt; wb_ack = 1; #1;
    checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL single_ack got a%b b%b exp a1 b0", a_ack, b_ack); end
    nxt; wb_ack = 0; a_cyc = 0; #1;
    checks++; if (a_ack !== 1'b0 || wb_cyc !== 1'b0 || owner !== 2'b01) begin errors++; $display("FAIL single_drop got %b/%b/%b exp 0/0/01", a_ack, wb_cyc, owner); end
    nxt; #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", owner); end
  endtask

  task automatic test_burst_preempt;
    int nacc, nack, fwd, ack16, gntb;
    logic acc, acc1, acc2;
    nacc = 0; nack = 0; fwd = 0; ack16 = -1; gntb = -1; acc1 = 0; acc2 = 0;
    nxt; a_cyc = 1; a_stb = 1;
    nxt; b_cyc = 1;
    for (int i = 1; i <= 24; i++) begin
      wb_ack = acc2;
      #1;
      acc = wb_stb & ~wb_stall;
      if (acc) nacc++;
      if (a_ack) fwd++;
      if (wb_ack) begin nack++; if (nack == 16) ack16 = i; end
      if (owner == 2'b10 && gntb < 0) gntb = i;
      if (i == 17) begin
        checks++; if (a_stall !== 1'b1 || wb_stb !== 1'b0 || owner !== 2'b01) begin errors++; $display("FAIL burst_preempt got %b/%b/%b exp 1/0/01", a_stall, wb_stb, owner); end
      end
      if (i == 18) begin
        checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b0 || a_stall !== 1'b1 || owner !== 2'b01) begin errors++; $display("FAIL burst_drain got %b/%b/%b/%b exp 1/0/1/01", wb_cyc, wb_stb, a_stall, owner); end
      end
      acc2 = acc1; acc1 = acc;
      nxt;
    end
    checks++; if (nacc !== 16) begin errors++; $display("FAIL burst_count got %0d exp 16", nacc); end
    checks++; if (fwd !== 16) begin errors++; $display("FAIL burst_acks got %0d exp 16", fwd); end
    checks++; if (ack16 !== 18) begin errors++; $display("FAIL burst_ack16 got %0d exp 18", ack16); end
    checks++; if (gntb !== 19) begin errors++; $display("FAIL burst_handoff got %0d exp 19", gntb); end
    #1;
    checks++; if (b_stall !== 1'b0 || a_stall !== 1'b1) begin errors++; $display("FAIL burst_b_owns got a%b b%b exp a1 b0", a_stall, b_stall); end
    wb_ack = 0; a_cyc = 0; a_stb = 0; b_cyc = 0;
    nxt; nxt;
  endtask

  task automatic test_bus_error;
    nxt; b_cyc = 1; b_stb = 1; b_we = 1; b_data = 32'hCAFE_0001; #1;
    nxt; #1;
    checks++; if (owner !== 2'b10 || wb_we !== 1'b1 || wb_data !== 32'hCAFE_0001) begin errors++; $display("FAIL err_grant got %b/%b/%h exp 10/1/cafe0001", owner, wb_we, wb_data); end
    nxt; nxt; nxt;
    nxt; b_stb = 0; wb_ack = 1; #1;
    checks++; if (dut.out_q !== 5'd4 || b_ack !== 1'b1) begin errors++; $display("FAIL err_outstanding got %0d/%b exp 4/1", dut.out_q, b_ack); end
    nxt; wb_ack = 0; wb_err = 1; #1;
    checks++; if (b_err !== 1'b1 || a_err !== 1'b0 || wb_cyc !== 1'b1) begin errors++; $display("FAIL err_route got b%b a%b cyc%b exp b1 a0 cyc1", b_err, a_err, wb_cyc); end
    nxt; wb_err = 0; wb_ack = 1; #1;
    checks++; if (b_err !== 1'b0 || wb_cyc !== 1'b0 || b_ack !== 1'b0 || b_stall !== 1'b1) begin errors++; $display("FAIL err_gap got err%b cyc%b ack%b stall%b exp 0 0 0 1", b_err, wb_cyc, b_ack, b_stall); end
    checks++; if (dut.out_q !== 5'd0) begin errors++; $display("FAIL err_clear got %0d exp 0", dut.out_q); end
    nxt; wb_ack = 0; #1;
    checks++; if (wb_cyc !== 1'b1 || owner !== 2'b10) begin errors++; $display("FAIL err_resume got %b/%b exp 1/10", wb_cyc, owner); end
    b_cyc = 0; b_we = 0;
    nxt; nxt;
  endtask

  task automatic test_reset_mid;
    nxt; a_cyc = 1; a_stb = 1; #1;
    nxt; nxt; nxt;
    nxt; a_stb = 0; #1;
    checks++; if (dut.out_q !== 5'd3 || owner !== 2'b01 || wb_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0d/%b/%b exp 3/01/1", dut.out_q, owner, wb_cyc); end
    #1 rst = 1; #1;
    checks++; if (wb_cyc !== 1'b0 || owner !== 2'b00 || a_stall !== 1'b1 || b_stall !== 1'b1) begin errors++; $display("FAIL rstmid_async got %b/%b/%b%b exp 0/00/11", wb_cyc, owner, a_stall, b_stall); end
    checks++; if (dut.out_q !== 5'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", dut.out_q); end
    a_cyc = 0;
    nxt; rst = 0; wb_ack = 1; #1;
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("FAIL rstmid_lateack got a%b b%b exp 0 0", a_ack, b_ack); end
    nxt; wb_ack = 0;
    nxt;
  endtask

  task automatic test_timeout;
    int errc;
    errc = -1;
    nxt; a_cyc = 1; a_stb = 1; #1;
    nxt; #1;
    checks++; if (owner !== 2'b01 || wb_stb !== 1'b1) begin errors++; $display("FAIL to_grant got %b/%b exp 01/1", owner, wb_stb); end
    nxt; a_stb = 0;
`ifdef WBSCHED_TIMEOUT_EN
    for (int i = 2; i <= 40 && errc < 0; i++) begin
      #1;
      if (a_err) errc = i; else nxt;
    end
    checks++; if (errc !== 16) begin errors++; $display("FAIL to_cycle got %0d exp 16", errc); end
    nxt; #1;
    checks++; if (wb_cyc !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL to_gap got %b/%b exp 0/0", wb_cyc, a_err); end
    a_cyc = 0;
    nxt; #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL to_release got %b exp 00", owner); end
`else
    for (int i = 2; i <= 40; i++) begin
      #1;
      if (a_err && errc < 0) errc = i;
      nxt;
    end
    #1;
    checks++; if (errc !== -1) begin errors++; $display("FAIL hang_noerr got %0d exp -1", errc); end
    checks++; if (owner !== 2'b01 || wb_cyc !== 1'b1) begin errors++; $display("FAIL hang_hold got %b/%b exp 01/1", owner, wb_cyc); end
    a_cyc = 0;
    nxt; #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL hang_release got %b exp 00", owner); end
`endif
  endtask

  initial begin
    test_reset;
    test_both_same_cycle;
    test_single_a;
    test_burst_preempt;
    test_bus_error;
    test_reset_mid;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
